// File: rtl/lvda_dor_pkg.sv
// Shared types for the LVDA discrete-output register loader.
// Holds the apply-mode encodings and the loader state enum.
package lvda_dor_pkg;

   typedef enum logic [1:0] {
      MODE_WRITE = 2'b00,
      MODE_SET   = 2'b01,
      MODE_CLEAR = 2'b10,
      MODE_RSVD  = 2'b11
   } dor_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      READY,
      APPLY
   } dor_state_e;

endpackage

// File: rtl/dor_watchdog.sv
// Idle-cycle watchdog for the DOR loader; expire pulses for one cycle
// on the TIMEOUT-th consecutive enabled cycle without a kick.
// Ports: clk, rst_n (async low), enable, kick -> expire.
module dor_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic kick,
   output logic expire
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;

   assign expire = enable && !kick && (cnt_q == LAST);

   // Counter parks at zero on expiry; the loader leaves SHIFT/READY
   // on the same edge, so it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!enable || kick || expire) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/lvda_dor_loader.sv
// LVDA discrete-output register loader: shifts in a serial command
// word and applies it to DOR as write, set or clear on LOAD.
// Ports: SIM_CLK, SIM_RST (async low), SDATA, SSTB, LOAD, DOMODE,
// ERRCLR -> DOR, BUSY, DOERR, DOR6H/8H/9H/10H (DOR taps).
// Option LVDA_DOR_PARITY_EN: WIDTH+1 bit word, last bit odd parity.
module lvda_dor_loader
   import lvda_dor_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic             SIM_CLK,
   input  logic             SIM_RST,
   input  logic             SDATA,
   input  logic             SSTB,
   input  logic             LOAD,
   input  logic [1:0]       DOMODE,
   input  logic             ERRCLR,
   output logic [WIDTH-1:0] DOR,
   output logic             BUSY,
   output logic             DOERR,
   output logic             DOR6H,
   output logic             DOR8H,
   output logic             DOR9H,
   output logic             DOR10H
);

`ifdef LVDA_DOR_PARITY_EN
   localparam int WORD_LEN = WIDTH + 1;
`else
   localparam int WORD_LEN = WIDTH;
`endif
   localparam int CNTW = $clog2(WORD_LEN + 1);
   localparam logic [CNTW-1:0] LAST = CNTW'(WORD_LEN);

   dor_state_e       state_q, state_d;
   dor_mode_e        mode_q, mode_d;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] dor_q, dor_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [CNTW-1:0]  cnt_inc;
   logic             busy_q;
   logic             err_q;
   logic             err_set;
   logic             take;
   logic             shift_sr;
   logic             par_ok;
   logic             wd_en;
   logic             wd_expire;

   assign cnt_inc = cnt_q + 1'b1;

`ifdef LVDA_DOR_PARITY_EN
   logic par_q;
   logic shift_par;

   // Data bits fill sr; the trailing bit lands in par_q.
   assign shift_sr  = take && (cnt_q < CNTW'(WIDTH));
   assign shift_par = take && (cnt_q == CNTW'(WIDTH));
   assign par_ok    = ^{sr_q, par_q};

   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         par_q <= 1'b0;
      end else if (shift_par) begin
         par_q <= SDATA;
      end
   end
`else
   assign shift_sr = take;
   assign par_ok   = 1'b1;
`endif

   assign wd_en = (state_q == SHIFT) || (state_q == READY);

   dor_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wdog (
      .clk   (SIM_CLK),
      .rst_n (SIM_RST),
      .enable(wd_en),
      .kick  (SSTB | LOAD),
      .expire(wd_expire)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      dor_d   = dor_q;
      cnt_d   = cnt_q;
      err_set = 1'b0;
      take    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (SSTB) begin
               take    = 1'b1;
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == LAST) ? READY : SHIFT;
            end else if (LOAD) begin
               err_set = 1'b1;
            end
         end
         SHIFT: begin
            if (wd_expire || LOAD) begin
               err_set = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (SSTB) begin
               take  = 1'b1;
               cnt_d = cnt_inc;
               if (cnt_inc == LAST) begin
                  state_d = READY;
               end
            end
         end
         READY: begin
            cnt_d   = '0;
            state_d = IDLE;
            if (LOAD && par_ok) begin
               mode_d  = dor_mode_e'(DOMODE);
               state_d = APPLY;
            end else if (LOAD || SSTB || wd_expire) begin
               err_set = 1'b1;
            end else begin
               cnt_d   = cnt_q;
               state_d = READY;
            end
         end
         APPLY: begin
            state_d = IDLE;
            unique case (mode_q)
               MODE_WRITE: dor_d = sr_q;
               MODE_SET:   dor_d = dor_q | sr_q;
               MODE_CLEAR: dor_d = dor_q & ~sr_q;
               default:    err_set = 1'b1;
            endcase
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         state_q <= IDLE;
         mode_q  <= MODE_WRITE;
         sr_q    <= '0;
         dor_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         dor_q   <= dor_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != IDLE);
         if (shift_sr) begin
            sr_q <= {sr_q[WIDTH-2:0], SDATA};
         end
         // A new error outranks a coincident clear.
         if (err_set) begin
            err_q <= 1'b1;
         end else if (ERRCLR) begin
            err_q <= 1'b0;
         end
      end
   end

   assign DOR    = dor_q;
   assign BUSY   = busy_q;
   assign DOERR  = err_q;
   assign DOR6H  = dor_q[6];
   assign DOR8H  = dor_q[8];
   assign DOR9H  = dor_q[9];
   assign DOR10H = dor_q[10];

endmodule

// File: tb/tb_lvda_dor_loader.sv
// Self-checking bench for lvda_dor_loader: directed plan plus
// randomized traffic against a queue-based behavioural model.
module tb_lvda_dor_loader;

   localparam int WIDTH   = 16;
   localparam int TIMEOUT = 1024;
`ifdef LVDA_DOR_PARITY_EN
   localparam int WLEN = WIDTH + 1;
`else
   localparam int WLEN = WIDTH;
`endif

   logic             SIM_CLK = 1'b0;
   logic             SIM_RST = 1'b0;
   logic             SDATA   = 1'b0;
   logic             SSTB    = 1'b0;
   logic             LOAD    = 1'b0;
   logic [1:0]       DOMODE  = 2'b00;
   logic             ERRCLR  = 1'b0;
   logic [WIDTH-1:0] DOR;
   logic             BUSY;
   logic             DOERR;
   logic             DOR6H, DOR8H, DOR9H, DOR10H;

   int checks = 0;
   int errors = 0;

   lvda_dor_loader #(
      .WIDTH(WIDTH),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .SIM_CLK(SIM_CLK),
      .SIM_RST(SIM_RST),
      .SDATA  (SDATA),
      .SSTB   (SSTB),
      .LOAD   (LOAD),
      .DOMODE (DOMODE),
      .ERRCLR (ERRCLR),
      .DOR    (DOR),
      .BUSY   (BUSY),
      .DOERR  (DOERR),
      .DOR6H  (DOR6H),
      .DOR8H  (DOR8H),
      .DOR9H  (DOR9H),
      .DOR10H (DOR10H)
   );

   always #5 SIM_CLK = ~SIM_CLK;

   // Behavioural model: received bits in a queue, a word-open flag,
   // a pending-apply flag and an idle-cycle count.
   logic             mq[$];
   bit               m_in;
   bit               m_pend;
   logic [1:0]       m_mode;
   logic [WIDTH-1:0] m_word;
   logic [WIDTH-1:0] m_dor;
   logic             m_err;
   int               m_idle;

   task automatic model_reset();
      mq.delete();
      m_in   = 0;
      m_pend = 0;
      m_mode = 2'b00;
      m_word = '0;
      m_dor  = '0;
      m_err  = 1'b0;
      m_idle = 0;
   endtask

   function automatic bit parity_ok();
      logic x;
      x = 1'b0;
      foreach (mq[i]) x = x ^ mq[i];
`ifdef LVDA_DOR_PARITY_EN
      return x == 1'b1;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [WIDTH-1:0] word_of();
      logic [WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < WIDTH; i++) w = {w[WIDTH-2:0], mq[i]};
      return w;
   endfunction

   task automatic model_step();
      bit set_e;
      bit full;
      set_e = 0;
      if (m_pend) begin
         m_pend = 0;
         case (m_mode)
            2'b00:   m_dor = m_word;
            2'b01:   m_dor = m_dor | m_word;
            2'b10:   m_dor = m_dor & ~m_word;
            default: set_e = 1;
         endcase
      end else if (!m_in) begin
         if (SSTB) begin
            mq.delete();
            mq.push_back(SDATA);
            m_in   = 1;
            m_idle = 0;
         end else if (LOAD) begin
            set_e = 1;
         end
      end else begin
         full = (mq.size() == WLEN);
         if (!SSTB && !LOAD) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               set_e = 1;
               m_in  = 0;
            end
         end else begin
            m_idle = 0;
            if (LOAD) begin
               m_in = 0;
               if (!full || !parity_ok()) begin
                  set_e = 1;
               end else begin
                  m_word = word_of();
                  m_mode = DOMODE;
                  m_pend = 1;
               end
            end else if (full) begin
               set_e = 1;
               m_in  = 0;
            end else begin
               mq.push_back(SDATA);
            end
         end
      end
      if (set_e) m_err = 1'b1;
      else if (ERRCLR) m_err = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp,
                  $time);
      end
   endtask

   // One clock: drive, let model follow the edge, compare at negedge.
   task automatic tick(input logic s, input logic d, input logic l,
                       input logic [1:0] m, input logic ec);
      SSTB   = s;
      SDATA  = d;
      LOAD   = l;
      DOMODE = m;
      ERRCLR = ec;
      @(posedge SIM_CLK);
      model_step();
      @(negedge SIM_CLK);
      chk("dor", 32'(DOR), 32'(m_dor));
      chk("busy", 32'(BUSY), 32'(m_in || m_pend));
      chk("doerr", 32'(DOERR), 32'(m_err));
      chk("taps", {28'd0, DOR10H, DOR9H, DOR8H, DOR6H},
          {28'd0, m_dor[10], m_dor[9], m_dor[8], m_dor[6]});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 2'b00, 0);
   endtask

   task automatic shift_word(input logic [WIDTH-1:0] d, input bit badpar,
                             input int gmax);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         tick(1, d[i], 0, 2'b00, 0);
         if (gmax > 0) idle($urandom_range(0, gmax));
      end
`ifdef LVDA_DOR_PARITY_EN
      tick(1, (~(^d)) ^ badpar, 0, 2'b00, 0);
`endif
   endtask

   task automatic apply(input logic [WIDTH-1:0] d, input logic [1:0] m);
      shift_word(d, 0, 0);
      tick(0, 0, 1, m, 0);
      tick(0, 0, 0, 2'b00, 0);
   endtask

   initial begin
      logic [WIDTH-1:0] rd;
      logic [1:0]       md;
      model_reset();
      repeat (3) @(negedge SIM_CLK);
      chk("rst_dor", 32'(DOR), 32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);
      chk("rst_doerr", 32'(DOERR), 32'h0);
      SIM_RST = 1'b1;
      idle(2);

      // Write with one-edge apply latency.
      shift_word(16'h0740, 0, 0);
      tick(0, 0, 1, 2'b00, 0);
      chk("wr_lat_dor", 32'(DOR), 32'h0);
      chk("wr_lat_busy", 32'(BUSY), 32'h1);
      tick(0, 0, 0, 2'b00, 0);
      chk("wr_dor", 32'(DOR), 32'h0740);
      chk("wr_model", 32'(m_dor), 32'h0740);
      chk("wr_busy", 32'(BUSY), 32'h0);
      chk("wr_taps", {28'd0, DOR10H, DOR9H, DOR8H, DOR6H}, 32'hf);

      // Async reset mid-word.
      tick(0, 0, 1, 2'b00, 0);
      for (int i = 0; i < 5; i++) tick(1, 1, 0, 2'b00, 0);
      #3 SIM_RST = 1'b0;
      model_reset();
      #1;
      chk("arst_dor", 32'(DOR), 32'h0);
      chk("arst_busy", 32'(BUSY), 32'h0);
      chk("arst_doerr", 32'(DOERR), 32'h0);
      @(negedge SIM_CLK);
      SIM_RST = 1'b1;
      apply(16'h0040, 2'b00);
      chk("post_rst_dor", 32'(DOR), 32'h0040);

      // Set, clear, reserved.
      apply(16'h0500, 2'b01);
      chk("set_dor", 32'(DOR), 32'h0540);
      apply(16'h0040, 2'b10);
      chk("clr_dor", 32'(DOR), 32'h0500);
      apply(16'hffff, 2'b11);
      chk("rsvd_dor", 32'(DOR), 32'h0500);
      chk("rsvd_err", 32'(DOERR), 32'h1);
      tick(0, 0, 0, 2'b00, 1);
      chk("errclr", 32'(DOERR), 32'h0);

      // Early LOAD after 7 strobes.
      for (int i = 0; i < 7; i++) tick(1, 1, 0, 2'b00, 0);
      tick(0, 0, 1, 2'b00, 0);
      chk("early_err", 32'(DOERR), 32'h1);
      chk("early_busy", 32'(BUSY), 32'h0);
      chk("early_dor", 32'(DOR), 32'h0500);
      tick(0, 0, 0, 2'b00, 1);
      chk("early_clr", 32'(DOERR), 32'h0);
      tick(0, 0, 1, 2'b00, 1);
      chk("clr_vs_set", 32'(DOERR), 32'h1);
      tick(0, 0, 0, 2'b00, 1);

      // Overrun.
      shift_word(16'hffff, 0, 0);
      tick(1, 1, 0, 2'b00, 0);
      chk("ovr_err", 32'(DOERR), 32'h1);
      chk("ovr_busy", 32'(BUSY), 32'h0);
      chk("ovr_dor", 32'(DOR), 32'h0500);
      tick(0, 0, 0, 2'b00, 1);

      // Timeout after 3 strobes.
      for (int i = 0; i < 3; i++) tick(1, 0, 0, 2'b00, 0);
      idle(TIMEOUT - 1);
      chk("to_pre_err", 32'(DOERR), 32'h0);
      chk("to_pre_busy", 32'(BUSY), 32'h1);
      idle(1);
      chk("to_err", 32'(DOERR), 32'h1);
      chk("to_busy", 32'(BUSY), 32'h0);
      tick(0, 0, 0, 2'b00, 1);

      // SSTB coincident with LOAD in READY.
      shift_word(16'h1234, 0, 0);
      tick(1, 1, 1, 2'b00, 0);
      tick(0, 0, 0, 2'b00, 0);
      chk("coinc_dor", 32'(DOR), 32'h1234);
      chk("coinc_err", 32'(DOERR), 32'h0);

`ifdef LVDA_DOR_PARITY_EN
      shift_word(16'h0740, 0, 0);
      tick(0, 0, 1, 2'b00, 0);
      tick(0, 0, 0, 2'b00, 0);
      chk("par_ok_dor", 32'(DOR), 32'h0740);
      shift_word(16'h0001, 1, 0);
      tick(0, 0, 1, 2'b00, 0);
      tick(0, 0, 0, 2'b00, 0);
      chk("par_bad_dor", 32'(DOR), 32'h0740);
      chk("par_bad_err", 32'(DOERR), 32'h1);
      tick(0, 0, 0, 2'b00, 1);
`endif

      // Randomized traffic.
      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            rd = WIDTH'($urandom);
            shift_word(rd, ($urandom_range(0, 7) == 0), 2);
            idle($urandom_range(0, 2));
            md = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) md = 2'b11;
            tick(($urandom_range(0, 3) == 0), 1'($urandom), 1, md,
                 ($urandom_range(0, 7) == 0));
            tick(($urandom_range(0, 3) == 0), 1'($urandom), 0, 2'b00, 0);
         end else begin
            for (int k = 0; k < 20; k++) begin
               tick(($urandom_range(0, 9) < 3), 1'($urandom),
                    ($urandom_range(0, 9) == 0), 2'($urandom),
                    ($urandom_range(0, 19) == 0));
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
